// File: rtl/pipeline_stage_rr.sv
// Register-read pipeline stage: valid/ready payload register with load-use stall,
// synchronous flush and saturating stall counter. Define PIPE_SKID_EN for a skid entry.
module pipeline_stage_rr #(
  parameter int unsigned CTRL_W   = 22,
  parameter int unsigned RNUM_W   = 3,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned LOAD_BIT = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [RNUM_W-1:0] num_Rm_in,
  input  logic [RNUM_W-1:0] num_Rn_in,
  input  logic [RNUM_W-1:0] num_Rd_in,
  input  logic [IMM_W-1:0]  imm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_out,
  output logic [RNUM_W-1:0] num_Rm_out,
  output logic [RNUM_W-1:0] num_Rn_out,
  output logic [RNUM_W-1:0] num_Rd_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic              loads,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RNUM_W-1:0] rm;
    logic [RNUM_W-1:0] rn;
    logic [RNUM_W-1:0] rd;
    logic [IMM_W-1:0]  imm;
  } entry_t;

  entry_t            in_e;
  entry_t            out_q;
  logic              out_valid_q;
  logic              accept;
  logic              consume;
  logic              last_vld;
  logic              last_load;
  logic [RNUM_W-1:0] last_rd;

  assign in_e = {control_in, num_Rm_in, num_Rn_in, num_Rd_in, imm_in};

  assign load_use_hazard = in_valid & last_vld & last_load &
                           ((num_Rm_in == last_rd) | (num_Rn_in == last_rd));

`ifdef PIPE_SKID_EN
  entry_t skid_q;
  logic   skid_full;

  assign in_ready = rst & ~skid_full & ~load_use_hazard & ~flush;
`else
  assign in_ready = rst & (~out_valid_q | out_ready) & ~load_use_hazard & ~flush;
`endif

  assign accept  = in_valid & in_ready;
  assign consume = out_valid_q & out_ready;

`ifdef PIPE_SKID_EN
  // accept implies skid empty, so skid refill and skid drain never coincide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_full   <= 1'b0;
    end else if (consume) begin
      if (skid_full) begin
        out_q     <= skid_q;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_q <= in_e;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (out_valid_q) begin
        skid_q    <= in_e;
        skid_full <= 1'b1;
      end else begin
        out_q       <= in_e;
        out_valid_q <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= in_e;
      out_valid_q <= 1'b1;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_vld  <= 1'b0;
      last_load <= 1'b0;
      last_rd   <= '0;
    end else if (accept) begin
      last_vld  <= 1'b1;
      last_load <= control_in[LOAD_BIT];
      last_rd   <= num_Rd_in;
    end else begin
      last_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = out_valid_q;
  assign control_out = out_q.ctrl;
  assign num_Rm_out  = out_q.rm;
  assign num_Rn_out  = out_q.rn;
  assign num_Rd_out  = out_q.rd;
  assign imm_out     = out_q.imm;
  assign loads       = out_q.ctrl[LOAD_BIT] & out_valid_q;

endmodule

// File: tb/tb_pipeline_stage_rr.sv
// Directed-vector bench for pipeline_stage_rr; covers both PIPE_SKID_EN builds.
module tb_pipeline_stage_rr;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] control_in;
  logic [2:0]  num_Rm_in, num_Rn_in, num_Rd_in;
  logic [15:0] imm_in;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] control_out;
  logic [2:0]  num_Rm_out, num_Rn_out, num_Rd_out;
  logic [15:0] imm_out;
  logic        loads;
  logic        load_use_hazard;
  logic [3:0]  stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipeline_stage_rr #(
    .CTRL_W(22), .RNUM_W(3), .IMM_W(16), .LOAD_BIT(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
    .num_Rd_in(num_Rd_in), .imm_in(imm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .control_out(control_out), .num_Rm_out(num_Rm_out), .num_Rn_out(num_Rn_out),
    .num_Rd_out(num_Rd_out), .imm_out(imm_out),
    .loads(loads), .load_use_hazard(load_use_hazard), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [21:0] c, input logic [2:0] rm,
                       input logic [2:0] rn, input logic [2:0] rd, input logic [15:0] imm);
    in_valid   = v;
    control_in = c;
    num_Rm_in  = rm;
    num_Rn_in  = rn;
    num_Rd_in  = rd;
    imm_in     = imm;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  int exp_stall;
  int acc;

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 22'h3, 3'd1, 3'd2, 3'd3, 16'h1234);

    // reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ctrl", 32'(control_out), 32'd0);
    chk("rst_loads", 32'(loads), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    step(); step();
    chk("rst_held_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;

    // streaming four entries back to back
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 22'(i), 3'd0, 3'd0, 3'(i), 16'(i * 16));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ctrl", 32'(control_out), 32'(i));
      chk("stream_rd", 32'(num_Rd_out), 32'(i));
    end
    drive(1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0);
    step();
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_stall", 32'(stall_cnt), 32'd0);

    // load-use: A loads r3, B reads r3
    drive(1'b1, 22'h100, 3'd0, 3'd0, 3'd3, 16'h00A0);
    step();
    chk("lu_loads", 32'(loads), 32'd1);
    drive(1'b1, 22'h0, 3'd3, 3'd0, 3'd1, 16'h00B0);
    chk("lu_hazard", 32'(load_use_hazard), 32'd1);
    chk("lu_in_ready0", 32'(in_ready), 32'd0);
    step();
    chk("lu_stall_1", 32'(stall_cnt), 32'd1);
    chk("lu_hazard_gone", 32'(load_use_hazard), 32'd0);
    chk("lu_in_ready1", 32'(in_ready), 32'd1);
    step();
    chk("lu_b_valid", 32'(out_valid), 32'd1);
    chk("lu_b_rm", 32'(num_Rm_out), 32'd3);
    chk("lu_b_imm", 32'(imm_out), 32'h00B0);
    drive(1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0);
    step();

    // independent follower: no stall
    drive(1'b1, 22'h100, 3'd0, 3'd0, 3'd3, 16'h00C0);
    step();
    drive(1'b1, 22'h0, 3'd2, 3'd5, 3'd1, 16'h00D0);
    chk("nolu_hazard", 32'(load_use_hazard), 32'd0);
    chk("nolu_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("nolu_b_imm", 32'(imm_out), 32'h00D0);
    chk("nolu_stall", 32'(stall_cnt), 32'd1);
    drive(1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0);

    // backpressure then drain
    do_reset();
    out_ready = 1'b0;
    exp_stall = 0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 22'(8'h10 + acc), 3'd0, 3'd0, 3'd1, 16'(acc));
      chk("bp_in_ready", 32'(in_ready), 32'(acc < CAP));
      step();
      if (acc < CAP) acc++;
      else exp_stall++;
      chk("bp_stall", 32'(stall_cnt), 32'(exp_stall));
    end
    chk("bp_stall_total", 32'(stall_cnt), 32'(5 - CAP));
    drive(1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0);
    out_ready = 1'b1;
    for (int j = 0; j < CAP; j++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_ctrl", 32'(control_out), 32'(8'h10 + j));
      step();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // flush with stage full and input pending
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) begin
      if (k == CAP - 1) drive(1'b1, 22'h100 | 22'(k), 3'd0, 3'd0, 3'd3, 16'h0);
      else              drive(1'b1, 22'h20 + 22'(k), 3'd0, 3'd0, 3'd1, 16'h0);
      step();
    end
    chk("fl_full_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 22'h0, 3'd3, 3'd0, 3'd2, 16'h0EEE);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_stall_kept", 32'(stall_cnt), 32'd1);
    drive(1'b1, 22'h0, 3'd3, 3'd0, 3'd2, 16'h0F0F);
    chk("fl_no_hazard", 32'(load_use_hazard), 32'd0);
    chk("fl_accept", 32'(in_ready), 32'd1);
    step();
    chk("fl_b_imm", 32'(imm_out), 32'h0F0F);
    drive(1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0);
    step();
    chk("fl_skid_clear", 32'(out_valid), 32'd0);

    // saturation at 4'hF
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 22'h5, 3'd0, 3'd0, 3'd1, 16'h0);
    for (int c = 0; c < 10; c++) step();
    chk("sat_mid", 32'(stall_cnt), 32'(10 - CAP));
    for (int c = 0; c < 10; c++) step();
    chk("sat_end", 32'(stall_cnt), 32'hF);

    // async reset between edges
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 22'h1FF, 3'd1, 3'd2, 3'd3, 16'hBEEF);
    step();
    drive(1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0);
    chk("ar_pre_loads", 32'(loads), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_loads", 32'(loads), 32'd0);
    chk("ar_ctrl", 32'(control_out), 32'd0);
    chk("ar_imm", 32'(imm_out), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst = 1'b1;
    drive(1'b1, 22'h7, 3'd0, 3'd0, 3'd4, 16'h0055);
    chk("ar_first_ready", 32'(in_ready), 32'd1);
    step();
    chk("ar_first_accept", 32'(imm_out), 32'h0055);
    drive(1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_rr.md
# pipeline_stage_rr

Parametrised register-read pipeline stage with valid/ready flow control, load-use hazard stall, synchronous flush and a stall-cycle counter. It sits between decode and register read and supersedes the fixed-width enable-only stage register. The payload is control word, Rm/Rn/Rd register numbers and immediate. An optional skid entry decouples `in_ready` from `out_ready`.

## Interface
Parameters:
- CTRL_W, 22, control word width
- RNUM_W, 3, register-number width
- IMM_W, 16, immediate width
- LOAD_BIT, 8, index of the "is load" bit in the control word (0 ≤ LOAD_BIT < CTRL_W)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts this cycle
- control_in  in  CTRL_W  control word
- num_Rm_in, num_Rn_in, num_Rd_in  in  RNUM_W each  register numbers
- imm_in  in  IMM_W  immediate
- out_valid  out  1  output register holds an entry
- out_ready  in  1  downstream consumes this cycle
- control_out, num_Rm_out, num_Rn_out, num_Rd_out, imm_out  out  matching widths  held payload
- loads  out  1  control_out[LOAD_BIT] & out_valid
- load_use_hazard  out  1  combinational hazard flag
- stall_cnt  out  CNT_W  saturating count of stalled input cycles

## Operation
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Hazard tracking:
  - Registers last_vld, last_load, last_rd capture the most recent accepted entry.
  - On accept: last_vld ← 1, last_load ← control_in[LOAD_BIT], last_rd ← num_Rd_in.
  - On any cycle without accept: last_vld ← 0.
- load_use_hazard = in_valid & last_vld & last_load & (num_Rm_in==last_rd | num_Rn_in==last_rd).
  - A hazard forces in_ready low.
  - Since last_vld then clears, exactly one bubble cycle is inserted per load-use pair.
- Flush:
  - Clears out_valid, the skid entry and last_vld.
  - Forces in_ready low that cycle; nothing is accepted.
  - Payload registers keep stale data.
  - Flush has priority over accept and consume.
- stall_cnt increments on in_valid & ~in_ready, saturating at 2^CNT_W−1. It is not cleared by flush.
- Ordering is strictly FIFO: out never overtakes skid.
- Payload registers load only on transfer; they do not toggle when idle.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid=0, all payload outputs=0, loads=0.
  - Skid empty, last_vld=0, stall_cnt=0.
  - in_ready=0 while rst=0.
- Latency: an entry accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1.
- Throughput: one entry per cycle with out_ready held high and no hazard.
- Simultaneous accept and consume with a single occupied entry: the output is replaced by the new entry, out_valid stays 1.
- Reset mid-transfer discards all entries; the first accept is allowed in the first cycle after rst rises.
- load_use_hazard and in_ready are valid combinationally in the same cycle as in_valid/payload.

## Configuration
- PIPE_SKID_EN defined:
  - Adds one skid entry behind the output register.
  - in_ready = ~skid_full & ~load_use_hazard & ~flush, which is independent of out_ready.
  - On accept with out_valid & ~out_ready, the entry goes to skid.
  - On consume with skid full, skid moves to the output register in the same edge.
  - Capacity is 2.
- PIPE_SKID_EN undefined:
  - Single entry.
  - in_ready = (~out_valid | out_ready) & ~load_use_hazard & ~flush.
  - Capacity is 1.

## Test plan
- Reset and streaming:
  - Stimulus: rst low for 2 cycles, then 4 back-to-back entries (control=22'h000001..4, Rd=1..4), out_ready=1.
  - Response: all outputs 0 during reset; entries appear in order one cycle after acceptance, one per cycle; stall_cnt=0.
- Load-use:
  - Stimulus: entry A with control[8]=1, Rd=3, then entry B with Rm=3.
  - Response: load_use_hazard=1 and in_ready=0 for exactly 1 cycle, B accepted next cycle, stall_cnt=1.
  - Repeat with B Rm=2, Rn=5: no stall.
- Backpressure:
  - Stimulus: out_ready=0 with in_valid=1 continuously.
  - Response with PIPE_SKID_EN: 2 entries accepted, then in_ready=0, stall_cnt grows by 1 per cycle.
  - Response without PIPE_SKID_EN: 1 entry accepted.
  - Then raise out_ready: entries drain in order with no loss or duplication.
- Flush:
  - Stimulus: flush=1 while out and skid are full and in_valid=1.
  - Response: next cycle out_valid=0, nothing accepted in the flush cycle; a following load-use pair does not stall.
- Counter saturation:
  - Stimulus: CNT_W=4, hold out_ready=0 and in_valid=1 for 20 cycles.
  - Response: stall_cnt stops at 4'hF.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with out_valid=1.
  - Response: out_valid, loads and payload go to 0 immediately, without waiting for a clock edge.
